table_fsm: RTL

TABLE_FSM -- requirements
Module: table_fsm

---
 rtl/table_fsm_pkg.sv | 28 ++
 rtl/table_fsm_table.sv | 37 +++
 rtl/table_fsm.sv | 81 ++++++++
 3 files changed

// File: rtl/table_fsm_pkg.sv
// rtl/table_fsm_pkg.sv - entry layout helpers shared by the table FSM and its bench
package table_fsm_pkg;

  localparam int DEF_SW = 3;
  localparam int DEF_IW = 1;
  localparam int DEF_OW = 3;
  localparam int DEF_DW = 1 + DEF_SW + DEF_OW;

  // Entry word is {valid, next_state, out}, out in the LSBs.
  localparam int ENTRY_OUT_LO = 0;

  function automatic int entry_next_lo(input int ow);
    return ow;
  endfunction

  function automatic int entry_valid_pos(input int sw, input int ow);
    return sw + ow;
  endfunction

  function automatic logic [DEF_DW-1:0] pack_entry(
    input logic              valid,
    input logic [DEF_SW-1:0] next_state,
    input logic [DEF_OW-1:0] out
  );
    return {valid, next_state, out};
  endfunction

endpackage

// File: rtl/table_fsm_table.sv
// rtl/table_fsm_table.sv - transition table: sync write, comb read, clearable valid bits
module fsm_table #(
  parameter int AW = 4,
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-2:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Payload fields are deliberately not reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) begin
      mem_q[wr_addr_i] <= wr_data_i[DW-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_addr_i] <= wr_data_i[DW-1];
    end
  end

  assign rd_data_o = {valid_q[rd_addr_i], mem_q[rd_addr_i]};

endmodule

// File: rtl/table_fsm.sv
// rtl/table_fsm.sv - table-driven Moore-style FSM with sticky invalid-entry error flag
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter int            SW        = 3,
  parameter int            IW        = 1,
  parameter int            OW        = 3,
  parameter logic [SW-1:0] RST_STATE = SW'(2),
  localparam int           AW        = SW + IW,
  localparam int           DW        = 1 + SW + OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [IW-1:0] a,
  input  logic          force_en,
  input  logic [SW-1:0] force_state,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [SW-1:0] state,
  output logic [OW-1:0] saida,
  output logic          err
);

  localparam int V_POS   = entry_valid_pos(SW, OW);
  localparam int NEXT_LO = entry_next_lo(OW);

  logic [SW-1:0] state_q, state_d;
  logic [OW-1:0] saida_q, saida_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_word;

  fsm_table #(
    .AW(AW),
    .DW(DW)
  ) u_table (
    .clk      (clk),
    .clr_i    (reset),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i({a, state_q}),
    .rd_data_o(rd_word)
  );

  // Lookup uses the pre-edge table contents, so a same-cycle write only affects later steps.
  always_comb begin
    state_d = state_q;
    saida_d = saida_q;
    err_d   = err_q;
    if (force_en) begin
      state_d = force_state;
    end else if (run) begin
      if (rd_word[V_POS]) begin
        state_d = rd_word[NEXT_LO +: SW];
        saida_d = rd_word[ENTRY_OUT_LO +: OW];
      end else begin
        state_d = RST_STATE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      saida_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      saida_q <= saida_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign saida = saida_q;
  assign err   = err_q;

endmodule
